// File: rtl/mem_arbiter_if.sv
// Bus bundle between the dcache/icache requesters, the RAM port and mem_arbiter.
// slave is the arbiter's view; master is the view of whoever drives the caches and RAM.
interface mem_arbiter_if;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 2;

  logic                dREN;
  logic                dWEN;
  logic [WORD_W-1:0]   daddr;
  logic [WORD_W-1:0]   dstore;
  logic                dwait;
  logic [WORD_W-1:0]   dload;

  logic                iREN;
  logic [WORD_W-1:0]   iaddr;
  logic                iwait;
  logic [WORD_W-1:0]   iload;

  logic                ramREN;
  logic                ramWEN;
  logic [WORD_W-1:0]   ramaddr;
  logic [WORD_W-1:0]   ramstore;
  logic [WORD_W-1:0]   ramload;
  logic [STATE_W-1:0]  ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter (dcache over icache) with a registered grant FSM.
// Define ARB_FAIR_EN to let the icache win the next decision after every data grant ends.
module mem_arbiter (
  input  logic           CLK,
  input  logic           nRST,
  mem_arbiter_if.slave   bus
);
  localparam int unsigned WORD_W     = 32;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_e;

  state_e state_q, state_d;
  state_e pick_c;
  logic   d_req_c;
  logic   ram_access_c;
  logic   favor_c;

  assign d_req_c      = bus.dREN | bus.dWEN;
  assign ram_access_c = (bus.ramstate == RAM_ACCESS);

`ifdef ARB_FAIR_EN
  logic ifavor_q, ifavor_d;

  // An icache word served this cycle already consumes the favour for this decision.
  assign favor_c = ifavor_q & ~((state_q == IGNT) & ram_access_c);

  always_comb begin
    ifavor_d = ifavor_q;
    if ((state_q == DGNT) && (state_d != DGNT)) begin
      ifavor_d = 1'b1;
    end else if ((state_q == IGNT) && ram_access_c) begin
      ifavor_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifavor_q <= 1'b0;
    end else begin
      ifavor_q <= ifavor_d;
    end
  end
`else
  assign favor_c = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shared grant decision used in IDLE, on data release and at the end of an icache word.
  always_comb begin
    pick_c = IDLE;
    if (bus.iREN && (favor_c || !d_req_c)) begin
      pick_c = IGNT;
    end else if (d_req_c) begin
      pick_c = DGNT;
    end
  end

  // Data grants are locked for as long as the request is held, so bursts stay whole.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = pick_c;
      DGNT: begin
        if (!d_req_c) begin
          state_d = pick_c;
        end
      end
      IGNT: begin
        if (ram_access_c || !bus.iREN) begin
          state_d = pick_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = WORD_W'(0);
    bus.ramstore = WORD_W'(0);
    bus.dwait    = 1'b1;
    bus.iwait    = 1'b1;
    bus.dload    = WORD_W'(0);
    bus.iload    = WORD_W'(0);
    unique case (state_q)
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.dwait    = ~ram_access_c;
        bus.dload    = bus.ramload;
      end
      IGNT: begin
        bus.ramaddr  = bus.iaddr;
        bus.ramREN   = bus.iREN;
        bus.iwait    = ~ram_access_c;
        bus.iload    = bus.ramload;
      end
      default: ;
    endcase
  end
endmodule
